pic_inta_ctrl: RTL and testbench
================================

# pic_inta_ctrl

Synchronous control unit for the 8259-style PIC. It decodes CPU command writes (ICW1/ICW2/ICW4 initialization, OCW1/OCW2 operation) into the configuration inputs of `InterruptBlock`, and it sequences the two-pulse INTA handshake that drives `intAcounter`. During the second INTA it places the vector byte on the data bus. It sits between the CPU bus interface and `InterruptBlock`; `rotate_set` drives that block's `set`, and its `reset` input is tied high.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles the controller waits in ACK1 for the second INTA. Used only with `PIC_INTA_TIMEOUT_EN`.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `wr_stb  in  1`: one-cycle write strobe from the bus interface.
- `a0  in  1`: address bit that selects the command word type.
- `wdata  in  8`: write data.
- `inta_n  in  1`: CPU interrupt acknowledge, active low, already synchronized to `clk`.
- `int_pending  in  1`: the `INTtocontrol` output of `InterruptBlock`.
- `isr_level  in  3`: the `ISRtocontrol` output of `InterruptBlock`.
- `int_cpu  out  1`: interrupt request to the CPU.
- `inta_count  out  2`: drives `intAcounter`. 00 = idle, 01 = first INTA, 10 = second INTA.
- `level_edge  out  1`: drives `level_or_edge_flag` (1 = level-triggered).
- `mask  out  8`: interrupt mask (OCW1).
- `rotate_set  out  1`: automatic rotation enable.
- `aeoi  out  1`: automatic EOI mode.
- `eoi  out  1`: one-cycle non-specific EOI pulse.
- `data_out  out  8`, `data_oe  out  1`: vector byte and its output enable.
- `init_done  out  1`: initialization sequence complete.
- `timeout_err  out  1`: one-cycle pulse when an INTA sequence is abandoned.

## Operation
- **Command decode**, applied on `wr_stb` only:
  - `a0`=0 with `wdata[4]`=1 is **ICW1**, accepted in any state.
    - `mask` becomes 00, `level_edge` becomes `wdata[3]`, the IC4 flag is latched from `wdata[0]`.
    - `init_done` becomes 0, `rotate_set` and `aeoi` become 0.
    - The INTA FSM is forced to IDLE.
    - The init FSM moves to WAIT_ICW2.
  - **WAIT_ICW2**, `a0`=1: the vector base becomes `wdata[7:3]`. Next state is WAIT_ICW4 if IC4 is set, otherwise READY.
  - **WAIT_ICW4**, `a0`=1: `aeoi` becomes `wdata[1]`, then READY.
    - ICW3 and cascade are not supported; ICW1 bit 1 is ignored.
  - Writes with `a0`=0 that are not ICW1 are ignored during WAIT_ICW2 and WAIT_ICW4.
  - **READY**, `a0`=1: **OCW1**, `mask` becomes `wdata`.
  - **READY**, `a0`=0 with `wdata[4:3]`=00: **OCW2**, decoded from `wdata[7:5]`:
    - 001: `eoi` pulse.
    - 101: `eoi` pulse and `rotate_set`=1.
    - 100: `rotate_set`=1.
    - 000: `rotate_set`=0.
    - All other codes are ignored.
  - **READY**, `wdata[4:3]`=01 (OCW3): ignored.
  - `init_done` is 1 exactly when the init FSM is in READY.
- **INTA FSM**, states IDLE, PEND, ACK1, ACK2. A falling edge is `inta_n` low with its registered previous value high.
  - **IDLE**: when `init_done` and `int_pending` are both 1, go to PEND.
  - **PEND**: `int_cpu` follows `int_pending`. On a falling edge, go to ACK1 and set `inta_count`=01.
    - The edge is accepted even if `int_pending` has dropped; `InterruptBlock` then supplies the spurious level 7.
  - **ACK1**: `int_cpu`=0. On a falling edge, go to ACK2, set `inta_count`=10, and set `data_out` = {base, `isr_level`}.
  - **ACK2**: `data_oe`=1 while `inta_n` is low. On the `inta_n` rising edge:
    - set `inta_count`=00 and `data_oe`=0;
    - go to IDLE.
- OCW writes are legal during an INTA sequence and do not disturb it.

## Timing
- **Reset values:**
  - `int_cpu`, `inta_count`, `level_edge`, `rotate_set`, `aeoi`, `eoi`, `data_out`, `data_oe`, `init_done` and `timeout_err` are all 0.
  - `mask` is FF.
  - Both FSMs return to their initial states: init FSM awaits ICW1, INTA FSM in IDLE.
- All outputs are registered and change in the cycle after the sampling edge.
- Registers update on the edge that samples `wr_stb`.
- `int_cpu` rises 2 cycles after `int_pending` rises (IDLE then PEND).
- `data_out` is valid in the cycle `data_oe` rises and is held until ACK2 exits.
- If ICW1 and an INTA edge occur in the same cycle, ICW1 wins.
- An asynchronous reset mid-sequence aborts immediately with no vector driven.

## Configuration
- `PIC_INTA_TIMEOUT_EN` defined:
  - An 8-bit counter is cleared on entry to ACK1 and increments each cycle in ACK1.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, `inta_count` becomes 00, and `timeout_err` pulses for 1 cycle.
- Undefined: ACK1 waits indefinitely and `timeout_err` is tied to 0.

## Structure
- Shared package `pic_pkg`:
  - INTA state enum;
  - init state enum;
  - OCW2 command codes (`OCW2_NS_EOI`, `OCW2_ROT_NS_EOI`, `OCW2_ROT_AEOI_SET`, `OCW2_ROT_AEOI_CLR`);
  - `inta_count` encodings.
- One sub-module, `pic_cmd_regs`, holds the ICW/OCW decode, the init FSM, and the configuration registers.
- `pic_inta_ctrl` holds the INTA FSM, the edge detector, the vector mux and the timeout counter.

## Test plan
- Reset, then ICW1=0x1B, ICW2=0x40, ICW4=0x02 → `level_edge`=1, `aeoi`=1, `mask`=00, `init_done`=1.
- After init, raise `int_pending` with `isr_level`=3 and apply two INTA pulses → `int_cpu` rises, `inta_count` goes 01 then 10, `data_out`=0x43 with `data_oe` during the second pulse, then `inta_count`=00.
- OCW2 write 0xA0 → `eoi` high for exactly 1 cycle and `rotate_set`=1. OCW2 write 0x00 → `rotate_set`=0.
- ICW1 written while in ACK1 → FSM to IDLE, `inta_count`=00, `init_done`=0, `mask`=00.
- With `PIC_INTA_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, apply one INTA pulse only → after 10 cycles, `timeout_err` pulses and `inta_count`=00.
- Assert `rst_n` low mid-ACK2 → `data_oe`=0 and `mask`=FF immediately.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared state types and encodings for the 8259-style PIC control unit.
package pic_pkg;

  typedef enum logic [1:0] {
    INTA_IDLE,
    INTA_PEND,
    INTA_ACK1,
    INTA_ACK2
  } inta_state_e;

  typedef enum logic [1:0] {
    INIT_WAIT_ICW1,
    INIT_WAIT_ICW2,
    INIT_WAIT_ICW4,
    INIT_READY
  } init_state_e;

  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;

  localparam logic [1:0] INTA_CNT_IDLE   = 2'b00;
  localparam logic [1:0] INTA_CNT_FIRST  = 2'b01;
  localparam logic [1:0] INTA_CNT_SECOND = 2'b10;

endpackage

// File: rtl/pic_cmd_regs.sv
// ICW/OCW command decode, initialization sequencer and configuration registers.
// icw1_o is combinational so the INTA FSM can be forced idle on the same edge.
module pic_cmd_regs
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_stb_i,
  input  logic       a0_i,
  input  logic [7:0] wdata_i,
  output logic       icw1_o,
  output logic [4:0] base_o,
  output logic       level_edge_o,
  output logic [7:0] mask_o,
  output logic       rotate_set_o,
  output logic       aeoi_o,
  output logic       eoi_o,
  output logic       init_done_o
);

  init_state_e init_q, init_d;
  logic [7:0]  mask_q, mask_d;
  logic [4:0]  base_q, base_d;
  logic        level_q, level_d;
  logic        ic4_q, ic4_d;
  logic        rot_q, rot_d;
  logic        aeoi_q, aeoi_d;
  logic        eoi_q, eoi_d;
  logic        done_q, done_d;

  assign icw1_o = wr_stb_i && !a0_i && wdata_i[4];

  always_comb begin
    init_d  = init_q;
    mask_d  = mask_q;
    base_d  = base_q;
    level_d = level_q;
    ic4_d   = ic4_q;
    rot_d   = rot_q;
    aeoi_d  = aeoi_q;
    eoi_d   = 1'b0;
    if (icw1_o) begin
      mask_d  = 8'h00;
      level_d = wdata_i[3];
      ic4_d   = wdata_i[0];
      rot_d   = 1'b0;
      aeoi_d  = 1'b0;
      init_d  = INIT_WAIT_ICW2;
    end else if (wr_stb_i) begin
      unique case (init_q)
        INIT_WAIT_ICW2: if (a0_i) begin
          base_d = wdata_i[7:3];
          init_d = ic4_q ? INIT_WAIT_ICW4 : INIT_READY;
        end
        INIT_WAIT_ICW4: if (a0_i) begin
          aeoi_d = wdata_i[1];
          init_d = INIT_READY;
        end
        INIT_READY: begin
          // OCW3 (bits 4:3 = 01) falls through and is deliberately ignored
          if (a0_i) begin
            mask_d = wdata_i;
          end else if (wdata_i[4:3] == 2'b00) begin
            unique case (wdata_i[7:5])
              OCW2_NS_EOI:       eoi_d = 1'b1;
              OCW2_ROT_NS_EOI:   begin eoi_d = 1'b1; rot_d = 1'b1; end
              OCW2_ROT_AEOI_SET: rot_d = 1'b1;
              OCW2_ROT_AEOI_CLR: rot_d = 1'b0;
              default:           ;
            endcase
          end
        end
        default: ;
      endcase
    end
    done_d = (init_d == INIT_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= INIT_WAIT_ICW1;
      mask_q  <= 8'hFF;
      base_q  <= 5'd0;
      level_q <= 1'b0;
      ic4_q   <= 1'b0;
      rot_q   <= 1'b0;
      aeoi_q  <= 1'b0;
      eoi_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      init_q  <= init_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      level_q <= level_d;
      ic4_q   <= ic4_d;
      rot_q   <= rot_d;
      aeoi_q  <= aeoi_d;
      eoi_q   <= eoi_d;
      done_q  <= done_d;
    end
  end

  assign base_o       = base_q;
  assign level_edge_o = level_q;
  assign mask_o       = mask_q;
  assign rotate_set_o = rot_q;
  assign aeoi_o       = aeoi_q;
  assign eoi_o        = eoi_q;
  assign init_done_o  = done_q;

endmodule

// File: rtl/pic_inta_ctrl.sv
// PIC control unit top: INTA handshake FSM, vector mux and command decode.
// Define PIC_INTA_TIMEOUT_EN to abandon an INTA sequence stuck in ACK1.
module pic_inta_ctrl
  import pic_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_stb,
  input  logic       a0,
  input  logic [7:0] wdata,
  input  logic       inta_n,
  input  logic       int_pending,
  input  logic [2:0] isr_level,
  output logic       int_cpu,
  output logic [1:0] inta_count,
  output logic       level_edge,
  output logic [7:0] mask,
  output logic       rotate_set,
  output logic       aeoi,
  output logic       eoi,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       init_done,
  output logic       timeout_err
);

  logic        icw1;
  logic [4:0]  base;
  inta_state_e state_q, state_d;
  logic        inta_prev_q;
  logic        fall, rise;
  logic [1:0]  count_q, count_d;
  logic        int_cpu_q, int_cpu_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;

  pic_cmd_regs u_cmd_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_stb_i     (wr_stb),
    .a0_i         (a0),
    .wdata_i      (wdata),
    .icw1_o       (icw1),
    .base_o       (base),
    .level_edge_o (level_edge),
    .mask_o       (mask),
    .rotate_set_o (rotate_set),
    .aeoi_o       (aeoi),
    .eoi_o        (eoi),
    .init_done_o  (init_done)
  );

  assign fall = !inta_n && inta_prev_q;
  assign rise = inta_n && !inta_prev_q;

`ifdef PIC_INTA_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmr_q, tmr_d;
  logic       terr_q, terr_d;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dout_d    = dout_q;
    int_cpu_d = 1'b0;
`ifdef PIC_INTA_TIMEOUT_EN
    tmr_d     = tmr_q;
    terr_d    = 1'b0;
`endif
    unique case (state_q)
      INTA_IDLE: if (init_done && int_pending) state_d = INTA_PEND;
      INTA_PEND: begin
        // A late edge is still honoured; the ISR block reports level 7 then
        if (fall) begin
          state_d = INTA_ACK1;
          count_d = INTA_CNT_FIRST;
`ifdef PIC_INTA_TIMEOUT_EN
          tmr_d   = 8'd0;
`endif
        end else begin
          int_cpu_d = int_pending;
        end
      end
      INTA_ACK1: begin
        if (fall) begin
          state_d = INTA_ACK2;
          count_d = INTA_CNT_SECOND;
          dout_d  = {base, isr_level};
        end
`ifdef PIC_INTA_TIMEOUT_EN
        else if (tmr_q == TIMEOUT_LAST) begin
          state_d = INTA_IDLE;
          count_d = INTA_CNT_IDLE;
          terr_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
`endif
      end
      INTA_ACK2: if (rise) begin
        state_d = INTA_IDLE;
        count_d = INTA_CNT_IDLE;
      end
      default: state_d = INTA_IDLE;
    endcase
    if (icw1) begin
      state_d   = INTA_IDLE;
      count_d   = INTA_CNT_IDLE;
      int_cpu_d = 1'b0;
`ifdef PIC_INTA_TIMEOUT_EN
      terr_d    = 1'b0;
`endif
    end
    oe_d = (state_d == INTA_ACK2) && !inta_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INTA_IDLE;
      inta_prev_q <= 1'b1;
      count_q     <= INTA_CNT_IDLE;
      int_cpu_q   <= 1'b0;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= inta_n;
      count_q     <= count_d;
      int_cpu_q   <= int_cpu_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
    end
  end

`ifdef PIC_INTA_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= 8'd0;
      terr_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  assign int_cpu    = int_cpu_q;
  assign inta_count = count_q;
  assign data_out   = dout_q;
  assign data_oe    = oe_q;

endmodule

// File: tb/tb_pic_inta_ctrl.sv
// Self-checking bench for pic_inta_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a cycle-level behavioural model.
module tb_pic_inta_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_stb = 1'b0;
  logic       a0 = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       inta_n = 1'b1;
  logic       int_pending = 1'b0;
  logic [2:0] isr_level = 3'd0;
  logic       int_cpu, level_edge, rotate_set, aeoi, eoi, data_oe, init_done, timeout_err;
  logic [1:0] inta_count;
  logic [7:0] mask, data_out;

  int total = 0;
  int bad = 0;

  localparam int TB_TIMEOUT = 10;

  pic_inta_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .a0(a0), .wdata(wdata),
    .inta_n(inta_n), .int_pending(int_pending), .isr_level(isr_level),
    .int_cpu(int_cpu), .inta_count(inta_count), .level_edge(level_edge),
    .mask(mask), .rotate_set(rotate_set), .aeoi(aeoi), .eoi(eoi),
    .data_out(data_out), .data_oe(data_oe), .init_done(init_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       a;
    logic [7:0] d;
    logic       ia;
    logic       p;
    logic [2:0] lv;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Expected pack: {int_cpu, inta_count, level_edge, mask, rotate_set, aeoi, eoi, data_out, data_oe, init_done}
  function automatic vec_t mkv(logic w, logic a, logic [7:0] d, logic ia, logic p, logic [2:0] lv,
                               logic cpu, logic [1:0] cnt, logic lvl, logic [7:0] msk, logic rot,
                               logic ae, logic eo, logic [7:0] dout, logic oe, logic done);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.ia = ia; v.p = p; v.lv = lv;
    v.exp = {cpu, cnt, lvl, msk, rot, ae, eo, dout, oe, done};
    return v;
  endfunction

  function automatic logic [25:0] dutOuts();
    return {int_cpu, inta_count, level_edge, mask, rotate_set, aeoi, eoi,
            data_out, data_oe, init_done, timeout_err};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic a, input logic [7:0] d,
                               input logic ia, input logic p, input logic [2:0] lv);
    wr_stb = w; a0 = a; wdata = d; inta_n = ia; int_pending = p; isr_level = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; wr_stb = 1'b0; a0 = 1'b0; wdata = 8'h00;
    inta_n = 1'b1; int_pending = 1'b0; isr_level = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic doInit();
    applyStimulus(1'b1, 1'b0, 8'h1B, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 3'd0);
  endtask

  // Behavioural model. initStep: 0 await ICW1, 1 await ICW2, 2 await ICW4, 3 ready.
  // phase: 0 quiet, 1 request raised, 2 first INTA seen, 3 second INTA seen.
  int         mInitStep, mPhase, mTimer;
  logic [7:0] mMask, mDout;
  logic [4:0] mBase;
  logic       mLevel, mIc4, mRot, mAeoi, mEoi, mCpu, mOe, mPrev, mTerr;
  logic [1:0] mCnt;

  task automatic modelReset();
    mInitStep = 0; mPhase = 0; mTimer = 0;
    mMask = 8'hFF; mDout = 8'h00; mBase = 5'd0;
    mLevel = 1'b0; mIc4 = 1'b0; mRot = 1'b0; mAeoi = 1'b0; mEoi = 1'b0;
    mCpu = 1'b0; mOe = 1'b0; mPrev = 1'b1; mTerr = 1'b0; mCnt = 2'd0;
  endtask

  task automatic modelStep(input logic w, input logic a, input logic [7:0] d,
                           input logic ia, input logic p, input logic [2:0] lv);
    logic fallSeen, riseSeen, wasReady;
    fallSeen = !ia && mPrev;
    riseSeen = ia && !mPrev;
    wasReady = (mInitStep == 3);
    mCpu = 1'b0; mEoi = 1'b0; mTerr = 1'b0;
    if (mPhase == 0) begin
      if (wasReady && p) mPhase = 1;
    end else if (mPhase == 1) begin
      if (fallSeen) begin mPhase = 2; mCnt = 2'd1; mTimer = 0; end
      else mCpu = p;
    end else if (mPhase == 2) begin
      if (fallSeen) begin mPhase = 3; mCnt = 2'd2; mDout = {mBase, lv}; end
`ifdef PIC_INTA_TIMEOUT_EN
      else begin
        mTimer = mTimer + 1;
        if (mTimer == TB_TIMEOUT) begin mPhase = 0; mCnt = 2'd0; mTerr = 1'b1; end
      end
`endif
    end else begin
      if (riseSeen) begin mPhase = 0; mCnt = 2'd0; end
    end
    if (w && !a && d[4]) begin
      mMask = 8'h00; mLevel = d[3]; mIc4 = d[0]; mRot = 1'b0; mAeoi = 1'b0;
      mInitStep = 1; mPhase = 0; mCnt = 2'd0; mCpu = 1'b0; mTerr = 1'b0;
    end else if (w) begin
      if (mInitStep == 1 && a) begin
        mBase = d[7:3]; mInitStep = mIc4 ? 2 : 3;
      end else if (mInitStep == 2 && a) begin
        mAeoi = d[1]; mInitStep = 3;
      end else if (mInitStep == 3) begin
        if (a) mMask = d;
        else if (d[4:3] == 2'b00) begin
          if (d[7:5] == 3'd1) mEoi = 1'b1;
          else if (d[7:5] == 3'd5) begin mEoi = 1'b1; mRot = 1'b1; end
          else if (d[7:5] == 3'd4) mRot = 1'b1;
          else if (d[7:5] == 3'd0) mRot = 1'b0;
        end
      end
    end
    mOe = (mPhase == 3) && !ia;
    mPrev = ia;
  endtask

  function automatic logic [25:0] modelOuts();
    return {mCpu, mCnt, mLevel, mMask, mRot, mAeoi, mEoi, mDout, mOe, (mInitStep == 3), mTerr};
  endfunction

  initial begin
    int firstTo, cntAtTo, seenTo, hold;
    logic rw, ra, ria, rp;
    logic [7:0] rd;
    logic [2:0] rlv;

    // Reset state
    doReset();
    checkOutput("reset outs", dutOuts(),
                {1'b0, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    checkOutput("reset mask", mask, 8'hFF);

    // Directed table: init, full handshake, OCW2/OCW1/OCW3, ICW1 in ACK1, ICW1 vs edge, IC4 path
    vecs.push_back(mkv(1'b1,1'b0,8'h1B,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0));
    vecs.push_back(mkv(1'b1,1'b1,8'h40,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0));
    vecs.push_back(mkv(1'b1,1'b1,8'h02,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h00,1'b0,1'b1,1'b0,8'h00,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd3, 1'b0,2'd0,1'b1,8'h00,1'b0,1'b1,1'b0,8'h00,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd3, 1'b1,2'd0,1'b1,8'h00,1'b0,1'b1,1'b0,8'h00,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b0,1'b1,3'd3, 1'b0,2'd1,1'b1,8'h00,1'b0,1'b1,1'b0,8'h00,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b0,1'b1,3'd3, 1'b0,2'd1,1'b1,8'h00,1'b0,1'b1,1'b0,8'h00,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd3, 1'b0,2'd1,1'b1,8'h00,1'b0,1'b1,1'b0,8'h00,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b0,1'b1,3'd3, 1'b0,2'd2,1'b1,8'h00,1'b0,1'b1,1'b0,8'h43,1'b1,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b0,1'b1,3'd3, 1'b0,2'd2,1'b1,8'h00,1'b0,1'b1,1'b0,8'h43,1'b1,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b0,3'd3, 1'b0,2'd0,1'b1,8'h00,1'b0,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b1,1'b0,8'hA0,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h00,1'b1,1'b1,1'b1,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h00,1'b1,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b1,1'b0,8'h00,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h00,1'b0,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b1,1'b1,8'h5A,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h5A,1'b0,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b1,1'b0,8'h08,1'b1,1'b0,3'd0, 1'b0,2'd0,1'b1,8'h5A,1'b0,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd5, 1'b0,2'd0,1'b1,8'h5A,1'b0,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd5, 1'b1,2'd0,1'b1,8'h5A,1'b0,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b0,1'b1,3'd5, 1'b0,2'd1,1'b1,8'h5A,1'b0,1'b1,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b1,1'b0,8'h10,1'b1,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b0));
    vecs.push_back(mkv(1'b1,1'b1,8'h88,1'b0,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b0,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd5, 1'b1,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b1,1'b0,8'h13,1'b0,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b0));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b0));
    vecs.push_back(mkv(1'b1,1'b1,8'hF8,1'b1,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b0));
    vecs.push_back(mkv(1'b1,1'b0,8'h20,1'b1,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b0));
    vecs.push_back(mkv(1'b1,1'b1,8'h00,1'b1,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd5, 1'b0,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b1));
    vecs.push_back(mkv(1'b0,1'b0,8'h00,1'b1,1'b1,3'd5, 1'b1,2'd0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h43,1'b0,1'b1));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].ia, vecs[i].p, vecs[i].lv);
      checkOutput($sformatf("vec %0d", i), 32'(dutOuts() >> 1), 32'(vecs[i].exp));
    end

    // Asynchronous reset in the middle of ACK2
    doReset();
    doInit();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3);
    checkOutput("ack2 oe", data_oe, 1);
    checkOutput("ack2 vector", data_out, 8'h43);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst oe", data_oe, 0);
    checkOutput("async rst mask", mask, 8'hFF);
    checkOutput("async rst cnt", inta_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single INTA pulse: ACK1 either times out or waits forever
    doReset();
    doInit();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1);
    checkOutput("one pulse cnt", inta_count, 1);
    firstTo = -1; cntAtTo = -1; seenTo = 0;
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1);
      if (timeout_err && firstTo < 0) begin
        firstTo = k; cntAtTo = 32'(inta_count); seenTo = 1;
`ifdef PIC_INTA_TIMEOUT_EN
        break;
`endif
      end
    end
`ifdef PIC_INTA_TIMEOUT_EN
    checkOutput("timeout cycle", firstTo, TB_TIMEOUT);
    checkOutput("timeout cnt", cntAtTo, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1);
    checkOutput("timeout pulse width", timeout_err, 0);
`else
    checkOutput("no timeout", seenTo, 0);
    checkOutput("ack1 held cnt", inta_count, 1);
`endif

    // Randomized traffic against the behavioural model
    doReset();
    modelReset();
    hold = 0;
    ria = 1'b1; rp = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rw = ($urandom_range(0, 5) == 0);
      ra = 1'b0; rd = 8'($urandom_range(0, 255));
      if (rw) begin
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 0) rd = rd | 8'h10;
        else if (kind <= 5) ra = 1'b1;
        else rd = rd & 8'hEF;
      end
      if (hold == 0) begin
        ria = ~ria;
        hold = $urandom_range(1, 6);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 7) == 0) rp = ~rp;
      rlv = 3'($urandom_range(0, 7));
      modelStep(rw, ra, rd, ria, rp, rlv);
      applyStimulus(rw, ra, rd, ria, rp, rlv);
      checkOutput($sformatf("rand cyc %0d", c), 32'(dutOuts()), 32'(modelOuts()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
